ring_sequencer: RTL and testbench
=================================

Name: ring_sequencer

Overview:
- Parametrised ring sequencer: the N-bit successor to the fixed 4-bit one-hot 1->2->4->8->1 counter.
- Adds run-time selection of one-hot ring or Johnson (twisted-ring) mode, rotation direction, a step enable, a wrap pulse and illegal-state detection and recovery.
- Used as a phase/slot generator for time-multiplexed datapaths and display scanning in lab designs.

Parameters:
N_BITS, 4, sequence register width (>=2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
en  input  1  advance one step when high
load  input  1  parallel load of data_in
data_in  input  N_BITS  load value, taken raw
mode  input  1  0 = one-hot ring, 1 = Johnson
dir  input  1  0 = toward MSB, 1 = toward LSB
count  output  N_BITS  current sequence value (registered)
wrap  output  1  registered one-cycle pulse on return to home state
illegal  output  1  combinational: count is not a legal state for current mode

Behaviour:
- Priority each posedge: reset > load > en > hold.
- Reset: count = 1 if mode=0, 0 if mode=1 (mode sampled at that edge); wrap = 0.
- Load: count <= data_in unconditionally, including illegal values; wrap <= 0.
- One-hot, dir=0: rotate left, MSB wraps to LSB (1->2->4->...->2^(N-1)->1). Home = 1.
- One-hot, dir=1: rotate right, LSB wraps to MSB. Home = 2^(N-1).
- One-hot legal: exactly one bit set.
- Johnson, dir=0: count <= {count[N-2:0], ~count[N-1]}. For N=4: 0000->0001->0011->0111->1111->1110->1100->1000->0000.
- Johnson, dir=1: count <= {~count[0], count[N-1:1]}.
- Johnson home = all zeros. Period = 2*N.
- Johnson legal: bits form one contiguous run of ones anchored at LSB or MSB, or all zeros/all ones; the 2*N states of the sequence.
- Enabled step from an illegal state: count <= reset value for current mode (recovery); wrap <= 0.
- wrap <= 1 only when an enabled step from a legal state lands on home; otherwise wrap <= 0. Never high after reset, load or recovery.
- en=0 with no load/reset: count holds; wrap <= 0.
- mode/dir may change any cycle and take effect on the next step.
  - A mode change can leave count illegal. illegal then rises immediately; the next enabled step recovers.
- Latency: count changes on the edge where en/load sampled; no pipeline.
- Reset mid-sequence or simultaneous with load/en: reset wins.
- Load with en: load wins, no step that cycle.

Optional Feature:
RING_SEQUENCER_POS_EN
- Defined: adds output pos, width $clog2(2*N_BITS), combinational from count and mode.
  - One-hot: index of the set bit.
  - Johnson: number of dir=0 steps from 0000 (0..2N-1).
  - pos = 0 when illegal.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package ring_seq_pkg:
  - typedef enum seq_mode_e {MODE_ONEHOT, MODE_JOHNSON}
  - typedef enum seq_dir_e {DIR_UP, DIR_DOWN}
  - function reset_value(mode)
- Sub-module ring_seq_next: purely combinational.
  - Inputs: count, mode, dir.
  - Outputs: next value, legal flag, lands_home flag.
- Top holds the count/wrap registers and the priority logic.

Test Plan:
- reset=1 mode=0, then en=1 for 5 cycles, N=4 -> count 1,2,4,8,1; wrap high only in the cycle count returns to 1.
- mode=0 dir=1 from reset, en=1 -> count 1,8,4,2,1; wrap when count=8 (home) is reached.
- mode=1 dir=0 from reset, en=1 for 8 cycles -> 0001,0011,0111,1111,1110,1100,1000,0000; wrap at 0000. Then dir=1 -> 1000.
- load data_in=0110 mode=0 -> illegal=1 next cycle; en=1 -> count=0001, wrap=0, illegal=0.
- load and en and reset together with count=0100 -> count=0001. Then load=1 en=1 data_in=0010 -> count=0010, no step.
- en=0 for 3 cycles at count=0100 -> count stays 0100, wrap=0.
- With RING_SEQUENCER_POS_EN in Johnson mode: count=0111 -> pos=3; count=1100 -> pos=6.

Source files
------------

// File: rtl/ring_seq_pkg.sv
// Shared types and helpers for the ring sequencer: mode/direction encodings
// and the per-mode reset (home-after-reset) value.
package ring_seq_pkg;

  localparam int unsigned MAX_BITS = 64;

  typedef enum logic {
    MODE_ONEHOT  = 1'b0,
    MODE_JOHNSON = 1'b1
  } seq_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } seq_dir_e;

  // Callers truncate to their own width; one-hot starts at bit 0, Johnson at zero.
  function automatic logic [MAX_BITS-1:0] reset_value(input seq_mode_e mode);
    logic [MAX_BITS-1:0] val;
    val = '0;
    if (mode == MODE_ONEHOT) begin
      val[0] = 1'b1;
    end
    return val;
  endfunction

endpackage

// File: rtl/ring_seq_next.sv
// Combinational step logic for the ring sequencer: next value, legality of the
// current value for the selected mode, and whether the step lands on home.
module ring_seq_next
  import ring_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 4
) (
  input  logic [N_BITS-1:0] count,
  input  logic              mode,
  input  logic              dir,
  output logic [N_BITS-1:0] next_c,
  output logic              legal_c,
  output logic              lands_home_c
);

  seq_mode_e         mode_e;
  seq_dir_e          dir_e;
  logic [N_BITS-1:0] home;
  logic [N_BITS-1:0] count_inv;
  logic              onehot_legal;
  logic              lsb_run;
  logic              msb_run;

  assign mode_e    = seq_mode_e'(mode);
  assign dir_e     = seq_dir_e'(dir);
  assign count_inv = ~count;

  // x & (x+1) == 0 means x is a run of ones anchored at bit 0 (incl. all-zero/all-one).
  always_comb begin
    onehot_legal = (count != '0) && ((count & (count - N_BITS'(1))) == '0);
    lsb_run      = ((count & (count + N_BITS'(1))) == '0);
    msb_run      = ((count_inv & (count_inv + N_BITS'(1))) == '0);
  end

  always_comb begin
    next_c  = count;
    home    = '0;
    legal_c = 1'b0;
    if (mode_e == MODE_ONEHOT) begin
      legal_c = onehot_legal;
      if (dir_e == DIR_UP) begin
        next_c  = {count[N_BITS-2:0], count[N_BITS-1]};
        home[0] = 1'b1;
      end else begin
        next_c         = {count[0], count[N_BITS-1:1]};
        home[N_BITS-1] = 1'b1;
      end
    end else begin
      legal_c = lsb_run || msb_run;
      if (dir_e == DIR_UP) begin
        next_c = {count[N_BITS-2:0], ~count[N_BITS-1]};
      end else begin
        next_c = {~count[0], count[N_BITS-1:1]};
      end
    end
    lands_home_c = (next_c == home);
  end

endmodule

// File: rtl/ring_sequencer.sv
// N-bit one-hot / Johnson ring sequencer with direction, enable, load, wrap pulse
// and illegal-state recovery. Define RING_SEQUENCER_POS_EN to add the pos output.
module ring_sequencer
  import ring_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [N_BITS-1:0] data_in,
  input  logic              mode,
  input  logic              dir,
  output logic [N_BITS-1:0] count,
  output logic              wrap,
  output logic              illegal
`ifdef RING_SEQUENCER_POS_EN
  ,
  output logic [$clog2(2*N_BITS)-1:0] pos
`endif
);

  logic [N_BITS-1:0] count_q;
  logic [N_BITS-1:0] count_d;
  logic              wrap_q;
  logic              wrap_d;
  logic [N_BITS-1:0] next_c;
  logic [N_BITS-1:0] rst_val;
  logic              legal_c;
  logic              lands_home_c;

  ring_seq_next #(
    .N_BITS(N_BITS)
  ) u_next (
    .count       (count_q),
    .mode        (mode),
    .dir         (dir),
    .next_c      (next_c),
    .legal_c     (legal_c),
    .lands_home_c(lands_home_c)
  );

  assign rst_val = N_BITS'(reset_value(seq_mode_e'(mode)));

  // Priority reset > load > en > hold; an enabled step from an illegal value recovers.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (reset) begin
      count_d = rst_val;
    end else if (load) begin
      count_d = data_in;
    end else if (en) begin
      if (legal_c) begin
        count_d = next_c;
        wrap_d  = lands_home_c;
      end else begin
        count_d = rst_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign illegal = ~legal_c;

`ifdef RING_SEQUENCER_POS_EN
  localparam int unsigned POS_W = $clog2(2*N_BITS);

  int ones;

  // Johnson position: LSB-anchored runs count up from zero, MSB-anchored runs count down from 2N.
  always_comb begin
    ones = $countones(count_q);
    pos  = '0;
    if (legal_c) begin
      if (seq_mode_e'(mode) == MODE_ONEHOT) begin
        for (int i = 0; i < int'(N_BITS); i++) begin
          if (count_q[i]) begin
            pos = POS_W'(i);
          end
        end
      end else if (count_q[0] || (count_q == '0)) begin
        pos = POS_W'(ones);
      end else begin
        pos = POS_W'(int'(2 * N_BITS) - ones);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed scoreboard bench for ring_sequencer (N_BITS=4): expected results are
// queued as each step is driven and compared once the clock edge has taken effect.
module tb_ring_sequencer;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] data_in;
  logic       mode;
  logic       dir;
  logic [3:0] count;
  logic       wrap;
  logic       illegal;
`ifdef RING_SEQUENCER_POS_EN
  logic [2:0] pos;
`endif

  typedef struct packed {
    logic [3:0] count;
    logic       wrap;
    logic       illegal;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    tests = 0;
  int    fails = 0;

  ring_sequencer #(
    .N_BITS(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .data_in(data_in),
    .mode   (mode),
    .dir    (dir),
    .count  (count),
    .wrap   (wrap),
    .illegal(illegal)
`ifdef RING_SEQUENCER_POS_EN
    ,
    .pos    (pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_sb();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    tests++;
    assert (count === e.count) else begin
      fails++;
      $error("FAIL %s.count observed=%b expected=%b", t, count, e.count);
    end
    tests++;
    assert (wrap === e.wrap) else begin
      fails++;
      $error("FAIL %s.wrap observed=%b expected=%b", t, wrap, e.wrap);
    end
    tests++;
    assert (illegal === e.illegal) else begin
      fails++;
      $error("FAIL %s.illegal observed=%b expected=%b", t, illegal, e.illegal);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic m,
                      input logic d, input logic [3:0] di, input logic [3:0] ec,
                      input logic ew, input logic ei, input string tag);
    exp_t x;
    @(negedge clk);
    reset   = r;
    load    = l;
    en      = e;
    mode    = m;
    dir     = d;
    data_in = di;
    x.count   = ec;
    x.wrap    = ew;
    x.illegal = ei;
    sb.push_back(x);
    tags.push_back(tag);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    dir     = 1'b0;
    data_in = 4'b0000;

    // One-hot, toward MSB
    step(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, "oh_up_reset");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, "oh_up_s1");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0100, 0, 0, "oh_up_s2");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, "oh_up_s3");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, "oh_up_wrap");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, "oh_up_s5");

    // One-hot, toward LSB: home is the MSB
    step(1, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0, "oh_dn_reset");
    step(0, 0, 1, 0, 1, 4'b0000, 4'b1000, 1, 0, "oh_dn_wrap");
    step(0, 0, 1, 0, 1, 4'b0000, 4'b0100, 0, 0, "oh_dn_s2");
    step(0, 0, 1, 0, 1, 4'b0000, 4'b0010, 0, 0, "oh_dn_s3");
    step(0, 0, 1, 0, 1, 4'b0000, 4'b0001, 0, 0, "oh_dn_s4");

    // Johnson, toward MSB, full period then reverse
    step(1, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, "jn_reset");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0, "jn_s1");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0, "jn_s2");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b0111, 0, 0, "jn_s3");
`ifdef RING_SEQUENCER_POS_EN
    tests++;
    assert (pos === 3'd3) else begin
      fails++;
      $error("FAIL jn_pos3 observed=%0d expected=3", pos);
    end
`endif
    step(0, 0, 1, 1, 0, 4'b0000, 4'b1111, 0, 0, "jn_s4");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0, "jn_s5");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b1100, 0, 0, "jn_s6");
`ifdef RING_SEQUENCER_POS_EN
    tests++;
    assert (pos === 3'd6) else begin
      fails++;
      $error("FAIL jn_pos6 observed=%0d expected=6", pos);
    end
`endif
    step(0, 0, 1, 1, 0, 4'b0000, 4'b1000, 0, 0, "jn_s7");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, "jn_wrap");
    step(0, 0, 1, 1, 1, 4'b0000, 4'b1000, 0, 0, "jn_dn_s1");
    step(0, 0, 1, 1, 1, 4'b0000, 4'b1100, 0, 0, "jn_dn_s2");

    // Mode change to one-hot leaves 1100 illegal immediately
    @(negedge clk);
    en   = 1'b0;
    mode = 1'b0;
    #1;
    tests++;
    assert (illegal === 1'b1) else begin
      fails++;
      $error("FAIL mode_switch_illegal observed=%b expected=1", illegal);
    end
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, "mode_switch_recover");

    // Illegal load then recovery in one-hot
    step(0, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 1, "oh_load_illegal");
    step(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, "oh_recover");

    // Johnson illegal load: recovery lands on home but must not pulse wrap
    step(0, 1, 0, 1, 0, 4'b0101, 4'b0101, 0, 1, "jn_load_illegal");
    step(0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, "jn_recover_nowrap");

    // Priority: reset beats load and en; load beats en
    step(0, 1, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, "load_0100");
    step(1, 1, 1, 0, 0, 4'b1000, 4'b0001, 0, 0, "reset_wins");
    step(0, 1, 1, 0, 0, 4'b0010, 4'b0010, 0, 0, "load_beats_en");

    // Loading home value is not a wrap
    step(0, 1, 1, 0, 0, 4'b0001, 4'b0001, 0, 0, "load_home_nowrap");

    // Hold with en low
    step(0, 1, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, "hold_load");
    step(0, 0, 0, 0, 0, 4'b1111, 4'b0100, 0, 0, "hold_1");
    step(0, 0, 0, 0, 0, 4'b1111, 4'b0100, 0, 0, "hold_2");
    step(0, 0, 0, 0, 0, 4'b1111, 4'b0100, 0, 0, "hold_3");

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
